// File: rtl/lsu_mem_stage_pkg.sv
// Shared widths, mem_op field positions, access-size codes and MEM-stage FSM states.
package lsu_mem_stage_pkg;

  localparam int LSU_XLEN  = 32;
  localparam int LSU_RF_AW = 5;

  localparam int MOP_ACCESS = 3;
  localparam int MOP_STORE  = 2;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational byte-lane logic: store byte enables/replication, misalignment, load extract/extend.
module lsu_align
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [1:0]      i_size,
  input  logic [1:0]      i_addr_lo,
  input  logic            i_unsigned,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_misal,
  output logic [XLEN-1:0] o_ld_data
);

  logic [XLEN-1:0] w_shifted;
  logic            w_sign;

  always_comb begin
    o_misal   = is_misaligned(i_size, i_addr_lo);
    w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    w_sign    = 1'b0;
    o_be      = 4'hF;
    o_wdata   = i_store_data;
    o_ld_data = w_shifted;
    case (i_size)
      SIZE_B: begin
        o_be      = 4'b0001 << i_addr_lo;
        o_wdata   = {(XLEN/8){i_store_data[7:0]}};
        w_sign    = w_shifted[7] & ~i_unsigned;
        o_ld_data = {{(XLEN-8){w_sign}}, w_shifted[7:0]};
      end
      SIZE_H: begin
        o_be      = 4'b0011 << i_addr_lo;
        o_wdata   = {(XLEN/16){i_store_data[15:0]}};
        w_sign    = w_shifted[15] & ~i_unsigned;
        o_ld_data = {{(XLEN-16){w_sign}}, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM stage: one-entry stage register plus req/gnt/rvalid bus FSM; 1 cycle for non-bus ops, >=2 for accesses.
// Holds results while out_ready is low; in_ready drops while an access (or a flushed one) is outstanding.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN          = LSU_XLEN,
  parameter int RF_ADDR_WIDTH = LSU_RF_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inst,
  input  logic                     in_rf_we,
  input  logic [RF_ADDR_WIDTH-1:0] in_rf_waddr,
  input  logic [XLEN-1:0]          in_alu_result,
  input  logic [XLEN-1:0]          in_store_data,
  input  logic [3:0]               in_mem_op,
  input  logic                     in_exp_flag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  output logic                     out_rf_we,
  output logic [RF_ADDR_WIDTH-1:0] out_rf_waddr,
  output logic [XLEN-1:0]          out_wb_data,
  output logic                     out_exp_flag,
  output logic                     out_ld_misal,
  output logic                     out_st_misal,
  output logic                     dbus_req,
  output logic                     dbus_we,
  output logic [XLEN-1:0]          dbus_addr,
  output logic [XLEN-1:0]          dbus_wdata,
  output logic [3:0]               dbus_be,
  input  logic                     dbus_gnt,
  input  logic                     dbus_rvalid,
  input  logic [XLEN-1:0]          dbus_rdata
);

  lsu_state_e r_state, w_state_nxt;

  logic                     r_valid;
  logic [XLEN-1:0]          r_pc, r_inst, r_alu, r_sdata, r_wb_data;
  logic                     r_rf_we, r_exp;
  logic [RF_ADDR_WIDTH-1:0] r_rf_waddr;
  logic [3:0]               r_mem_op;

  logic            w_capture, w_fire, w_in_need_bus, w_load_done;
  logic            w_misal, w_acc_misal, w_is_load;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata, w_ld_data;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_size       (r_mem_op[1:0]),
    .i_addr_lo    (r_alu[1:0]),
    .i_unsigned   (r_inst[14]),
    .i_store_data (r_sdata),
    .i_rdata      (dbus_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misal      (w_misal),
    .o_ld_data    (w_ld_data)
  );

  // Bus need is decided on the incoming fields so the request goes out the cycle after capture.
  assign w_in_need_bus = in_mem_op[MOP_ACCESS] && !in_exp_flag &&
                         !is_misaligned(in_mem_op[1:0], in_alu_result[1:0]);

  assign w_acc_misal = r_mem_op[MOP_ACCESS] && w_misal;
  assign w_is_load   = r_mem_op[MOP_ACCESS] && !r_mem_op[MOP_STORE];

  assign out_valid = r_valid && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_fire    = out_valid && out_ready;
  assign in_ready  = (r_state != ST_DRAIN) && (!r_valid || w_fire);
  assign w_capture = in_valid && in_ready && !flush;

  always_comb begin
    w_state_nxt = r_state;
    w_load_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_capture && w_in_need_bus) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // A grant coinciding with the flush still owes us a response, so drain it.
        if (flush) begin
          w_state_nxt = (dbus_gnt && !dbus_rvalid) ? ST_DRAIN : ST_IDLE;
        end else if (dbus_gnt) begin
          w_state_nxt = dbus_rvalid ? ST_DONE : ST_WAIT;
          w_load_done = dbus_rvalid;
        end
      end
      ST_WAIT: begin
        if (dbus_rvalid) begin
          w_state_nxt = flush ? ST_IDLE : ST_DONE;
          w_load_done = !flush;
        end else if (flush) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (flush || w_fire) w_state_nxt = (w_capture && w_in_need_bus) ? ST_REQ : ST_IDLE;
      end
      ST_DRAIN: begin
        if (dbus_rvalid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_inst     <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_alu      <= '0;
      r_sdata    <= '0;
      r_mem_op   <= '0;
      r_exp      <= 1'b0;
      r_wb_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_valid    <= 1'b1;
        r_pc       <= in_pc;
        r_inst     <= in_inst;
        r_rf_we    <= in_rf_we;
        r_rf_waddr <= in_rf_waddr;
        r_alu      <= in_alu_result;
        r_sdata    <= in_store_data;
        r_mem_op   <= in_mem_op;
        r_exp      <= in_exp_flag;
        r_wb_data  <= in_alu_result;
      end else if (flush || w_fire) begin
        r_valid <= 1'b0;
      end
      if (w_load_done && w_is_load) r_wb_data <= w_ld_data;
    end
  end

  assign out_pc       = r_pc;
  assign out_inst     = r_inst;
  assign out_rf_we    = r_rf_we && !w_acc_misal;
  assign out_rf_waddr = r_rf_waddr;
  assign out_wb_data  = r_wb_data;
  assign out_exp_flag = r_exp || w_acc_misal;
  assign out_ld_misal = w_acc_misal && !r_mem_op[MOP_STORE];
  assign out_st_misal = w_acc_misal && r_mem_op[MOP_STORE];

  assign dbus_req   = (r_state == ST_REQ);
  assign dbus_we    = r_mem_op[MOP_ACCESS] && r_mem_op[MOP_STORE];
  assign dbus_addr  = {r_alu[XLEN-1:2], 2'b00};
  assign dbus_wdata = w_wdata;
  assign dbus_be    = r_mem_op[MOP_ACCESS] ? w_be : 4'h0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Random EX-side traffic and bus responder against a transaction-level model of the MEM stage.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_inst = '0, in_alu_result = '0, in_store_data = '0;
  logic        in_rf_we = 1'b0;
  logic [4:0]  in_rf_waddr = '0;
  logic [3:0]  in_mem_op = '0;
  logic        in_exp_flag = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_inst, out_wb_data;
  logic        out_rf_we, out_exp_flag, out_ld_misal, out_st_misal;
  logic [4:0]  out_rf_waddr;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt = 1'b0, dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = '0;

  lsu_mem_stage #(.XLEN(32), .RF_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_mem_op(in_mem_op), .in_exp_flag(in_exp_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr),
    .out_wb_data(out_wb_data), .out_exp_flag(out_exp_flag),
    .out_ld_misal(out_ld_misal), .out_st_misal(out_st_misal),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc, inst, addr, sdata;
    logic [4:0]  rd;
    logic        rf_we, exp, access, store;
    logic [1:0]  size;
  } instr_t;

  function automatic logic misal(input instr_t t);
    if (t.size == 2'd1) return (t.addr % 2) != 0;
    if (t.size == 2'd2) return (t.addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic needs_bus(input instr_t t);
    return t.access && !t.exp && !misal(t);
  endfunction

  function automatic logic [3:0] exp_be(input instr_t t);
    int off;
    off = int'(t.addr % 4);
    if (t.size == 2'd0) return 4'(32'd1 << off);
    if (t.size == 2'd1) return 4'(32'd3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input instr_t t);
    if (t.size == 2'd0) return (t.sdata & 32'hFF) * 32'h0101_0101;
    if (t.size == 2'd1) return (t.sdata & 32'hFFFF) * 32'h0001_0001;
    return t.sdata;
  endfunction

  function automatic logic [31:0] ld_value(input instr_t t, input logic [31:0] rd);
    logic [31:0] v;
    int off;
    off = int'(t.addr % 4);
    v = rd >> (8 * off);
    if (t.size == 2'd0) begin
      v = v & 32'hFF;
      if (!t.inst[14] && v >= 32'h80) v = v - 32'h100;
    end else if (t.size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!t.inst[14] && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.pc     = $urandom & 32'hFFFF_FFFC;
    t.inst   = $urandom;
    t.addr   = $urandom;
    t.sdata  = $urandom;
    t.rd     = 5'($urandom);
    t.rf_we  = 1'($urandom);
    t.exp    = ($urandom_range(0, 15) == 0);
    t.access = ($urandom_range(0, 9) < 7);
    t.store  = 1'($urandom);
    t.size   = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 2) != 0) t.addr = t.addr - (t.addr % (32'd1 << t.size));
    return t;
  endfunction

  // Transaction-level model: one stage entry, whether it was granted / completed, and a drain debt.
  instr_t      m_cur, pend;
  logic [31:0] m_ld;
  bit m_has = 0, m_granted = 0, m_done = 0, m_drain = 0;
  bit just_rst, consumed, rst_hit;
  bit exp_req, exp_ov, exp_ir, outstanding, gnt, rv, fire, cap;

  task automatic check_reset_zero();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_dbus_req", 32'(dbus_req), 32'd0);
    check_eq("rst_dbus_addr", dbus_addr, 32'd0);
    check_eq("rst_dbus_be", 32'(dbus_be), 32'd0);
    check_eq("rst_dbus_we", 32'(dbus_we), 32'd0);
    check_eq("rst_dbus_wdata", dbus_wdata, 32'd0);
    check_eq("rst_out_pc", out_pc, 32'd0);
    check_eq("rst_out_wb", out_wb_data, 32'd0);
    check_eq("rst_out_flags", {28'd0, out_rf_we, out_exp_flag, out_ld_misal, out_st_misal}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    just_rst = 1;
    consumed = 0;
    rst_hit  = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst_n = 1'b1;
      if (just_rst) check_reset_zero();
      just_rst = 0;
      if (consumed) in_valid = 1'b0;
      consumed = 0;

      // One synchronous reset while an access is in flight on the bus.
      if (!rst_hit && cyc > 1500 && m_has && needs_bus(m_cur) && m_granted && !m_done) begin
        rst_hit = 1;
        rst_n = 1'b0;
        flush = 1'b0;
        dbus_gnt = 1'b0;
        dbus_rvalid = 1'b0;
        m_has = 0; m_granted = 0; m_done = 0; m_drain = 0;
        just_rst = 1;
        continue;
      end

      exp_req     = m_has && needs_bus(m_cur) && !m_granted;
      exp_ov      = m_has && (!needs_bus(m_cur) || m_done);
      outstanding = m_drain || (m_has && needs_bus(m_cur) && m_granted && !m_done);
      gnt = exp_req && ($urandom_range(0, 99) < 40);
      rv  = (outstanding || gnt) && ($urandom_range(0, 99) < 40);
      flush     = ($urandom_range(0, 99) < 4);
      out_ready = ($urandom_range(0, 99) < 70);
      if (!in_valid && $urandom_range(0, 99) < 60) begin
        pend = rand_instr();
        in_valid      = 1'b1;
        in_pc         = pend.pc;
        in_inst       = pend.inst;
        in_rf_we      = pend.rf_we;
        in_rf_waddr   = pend.rd;
        in_alu_result = pend.addr;
        in_store_data = pend.sdata;
        in_mem_op     = {pend.access, pend.store, pend.size};
        in_exp_flag   = pend.exp;
      end
      dbus_gnt    = gnt;
      dbus_rvalid = rv;
      dbus_rdata  = $urandom;
      #1;

      exp_ir = !m_drain && (!m_has || (exp_ov && out_ready));
      check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
      check_eq("dbus_req", 32'(dbus_req), 32'(exp_req));
      check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
      if (exp_req) begin
        check_eq("dbus_addr", dbus_addr, m_cur.addr - (m_cur.addr % 4));
        check_eq("dbus_be", 32'(dbus_be), 32'(exp_be(m_cur)));
        check_eq("dbus_we", 32'(dbus_we), 32'(m_cur.store));
        if (m_cur.store) check_eq("dbus_wdata", dbus_wdata, exp_wdata(m_cur));
      end
      if (exp_ov) begin
        check_eq("out_pc", out_pc, m_cur.pc);
        check_eq("out_inst", out_inst, m_cur.inst);
        check_eq("out_rf_waddr", 32'(out_rf_waddr), 32'(m_cur.rd));
        check_eq("out_rf_we", 32'(out_rf_we), 32'(m_cur.rf_we && !(m_cur.access && misal(m_cur))));
        check_eq("out_exp_flag", 32'(out_exp_flag), 32'(m_cur.exp || (m_cur.access && misal(m_cur))));
        check_eq("out_ld_misal", 32'(out_ld_misal), 32'(m_cur.access && !m_cur.store && misal(m_cur)));
        check_eq("out_st_misal", 32'(out_st_misal), 32'(m_cur.access && m_cur.store && misal(m_cur)));
        check_eq("out_wb_data", out_wb_data,
                 (needs_bus(m_cur) && !m_cur.store) ? m_ld : m_cur.addr);
      end

      fire = exp_ov && out_ready;
      cap  = in_valid && exp_ir && !flush;
      if (flush) begin
        m_drain = (outstanding || gnt) && !rv;
        m_has   = 0;
      end else begin
        if (m_drain) begin
          if (rv) m_drain = 0;
        end else if (m_has && needs_bus(m_cur) && !m_done) begin
          if (gnt) m_granted = 1;
          if (m_granted && rv) begin
            m_done = 1;
            m_ld   = ld_value(m_cur, dbus_rdata);
          end
        end
        if (fire) m_has = 0;
      end
      if (cap) begin
        m_cur = pend;
        m_has = 1; m_granted = 0; m_done = 0;
        consumed = 1;
      end
    end
    check_eq("reset_mid_wait_reached", 32'(rst_hit), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- MEM stage of the 5-stage core, between the EX stage and the MEM/WB pipeline register.
- Holds one instruction in its own stage register and performs its load/store on the data bus.
  - Bus handshake: req/gnt/rvalid.
  - Loads are aligned and sign/zero-extended.
  - Misaligned accesses are flagged.
- Presents valid/ready-qualified results downstream.
- The stage's ready_go is held low while a bus access is outstanding.

Parameters:
- XLEN, 32, data/address width.
- RF_ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- flush  in  1  kill instruction in stage (trap/redirect from WB)
- in_valid  in  1  EX has an instruction for this stage
- in_ready  out  1  stage can accept (allowin)
- in_pc, in_inst  in  XLEN  instruction PC/word
- in_rf_we  in  1  instruction writes rd
- in_rf_waddr  in  RF_ADDR_WIDTH  rd
- in_alu_result  in  XLEN  effective address or ALU result
- in_store_data  in  XLEN  rs2 value
- in_mem_op  in  4  [3]=access, [2]=store, [1:0]=size (0 B, 1 H, 2 W); in_inst[14] selects unsigned load
- in_exp_flag  in  1  upstream exception already raised
- out_valid  out  1  result valid to MEM/WB
- out_ready  in  1  MEM/WB allowin
- out_pc, out_inst  out  XLEN
- out_rf_we  out  1
- out_rf_waddr  out  RF_ADDR_WIDTH
- out_wb_data  out  XLEN
- out_exp_flag  out  1
- out_ld_misal, out_st_misal  out  1
- dbus_req  out  1
- dbus_we  out  1
- dbus_addr  out  XLEN  word-aligned
- dbus_wdata  out  XLEN  lane-replicated
- dbus_be  out  4
- dbus_gnt  in  1
- dbus_rvalid  in  1  completes both loads and stores
- dbus_rdata  in  XLEN

Behaviour:
- Reset:
  - All stage registers and outputs go to 0.
  - FSM goes to IDLE.
  - in_ready=1 after reset.
- Capture:
  - in_ready = !stage_valid || (out_valid && out_ready).
  - On in_valid && in_ready && !flush, latch all in_* fields; stage_valid<=1.
  - Otherwise, when out_valid && out_ready, stage_valid<=0.
- Misalignment:
  - H with addr[0]=1, or W with addr[1:0]!=0, is misaligned.
  - No bus request is made.
  - out_ld_misal / out_st_misal is set and out_exp_flag=1.
  - out_rf_we forced to 0.
- Access skip:
  - No bus request for access=0, in_exp_flag=1, or misaligned.
  - out_valid is high in the cycle after capture, giving 1-cycle latency.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - IDLE -> REQ: cycle after capture of a valid access.
  - REQ:
    - dbus_req=1; addr, we, be and wdata are stable.
    - On dbus_gnt -> WAIT.
  - WAIT:
    - On dbus_rvalid -> DONE.
    - On a load, latch the extended rdata into out_wb_data.
  - DONE:
    - out_valid=1.
    - When out_ready, go to IDLE, or to REQ if a new access is captured in the same cycle.
  - dbus_gnt and dbus_rvalid may arrive in the same cycle as the request or grant; each is an independent event. Minimum access latency: 2 cycles after capture.
- Byte lanes:
  - B: be=1<<addr[1:0].
  - H: be=3<<addr[1:0].
  - W: be=4'hF.
  - Store data replicated per size.
- Load extract:
  - Select byte/half by addr[1:0].
  - Sign-extend unless in_inst[14]=1.
- Non-load results: out_wb_data = in_alu_result.
- Flush:
  - Clears stage_valid and suppresses capture in the same cycle.
  - In REQ: drop req next cycle (no grant received yet) -> IDLE.
  - In WAIT: -> DRAIN. Absorb one dbus_rvalid, then IDLE. in_ready=0 while in DRAIN.
- Store side effect: a store that reached WAIT is committed on the bus even if flushed.
- out_valid=0 whenever stage_valid=0. Outputs hold while out_valid && !out_ready.

Decomposition:
- Shared defines header: XLEN, RF_ADDR_WIDTH, mem_op encodings, size codes, FSM state encodings, reset-enable/TRUE/FALSE macros.
- Sub-module lsu_align:
  - Combinational.
  - Computes be, wdata replication, misalignment and load extraction/extension.
  - Reused by a future I-side/AMO path.

Test Plan:
- ALU op, alu_result=0x1234, out_ready=1 -> out_valid 1 cycle after capture, no dbus_req, out_wb_data=0x1234.
- LB addr=0x1003, rdata=0x80FF_FF00, gnt same cycle, rvalid +1:
  - dbus_addr=0x1000, be=4'b1000.
  - out_wb_data=0xFFFF_FF80.
  - Repeat as LBU (inst[14]=1) -> 0x0000_0080.
- SH addr=0x2002, data=0xABCD -> dbus_we=1, be=4'b1100, wdata=0xABCD_ABCD; out_rf_we=0 after rvalid.
- LW addr=0x3001 -> no dbus_req, out_ld_misal=1, out_exp_flag=1, out_rf_we=0.
- Bus stalls: gnt delayed 3 cycles, rvalid 4 more, out_ready low 2 cycles in DONE:
  - req held stable throughout.
  - in_ready=0 throughout.
  - Outputs stable until out_ready; back-to-back load captured on the handoff cycle.
- Flush in WAIT -> DRAIN; rvalid 2 cycles later absorbed; no out_valid; in_ready returns 1 the cycle after rvalid.
- Also: flush in REQ -> req deasserts next cycle.
- Also: rst_n low mid-WAIT -> all outputs 0, state IDLE, next cycle.
